// File: rtl/bin_bcd_display.sv
// Multi-cycle binary-to-BCD converter (shift-add-3, one bit per clock) with
// optional signed input, leading-zero blanking, overflow flag and an
// active-low 7-segment encoder ({g,f,e,d,c,b,a} per field).
//
// state  | meaning
// IDLE   | waiting for start_i; captures magnitude and sign on start
// SHIFT  | one add-3/shift step per cycle, BIN_W cycles
// FINISH | scratch holds the final BCD; results are registered on exit

module bin_bcd_display #(
   parameter int BIN_W    = 16,
   parameter int DIGITS   = 5,
   parameter int SIGNED   = 0,
   parameter int BLANK_LZ = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [BIN_W-1:0]    bin_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [4*DIGITS-1:0] bcd_o,
   output logic                neg_o,
   output logic                ovf_o,
   output logic [7*DIGITS-1:0] seg_o
);

   // Scratch must hold every digit the input can produce, so the bits shifted
   // out never disappear before overflow is judged; at least one spare digit.
   localparam int NEED_D = (BIN_W * 3 + 9) / 10 + 1;
   localparam int SCR_D  = (DIGITS + 1 > NEED_D) ? DIGITS + 1 : NEED_D;
   localparam int CNT_W  = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FINISH
   } state_t;

   state_t               state_q, state_d;
   logic [BIN_W-1:0]     mag_q;
   logic [4*SCR_D-1:0]   scr_q;
   logic [4*SCR_D-1:0]   scr_adj;
   logic [CNT_W-1:0]     cnt_q;
   logic                 sign_q;
   logic                 neg_in;
   logic                 ovf_c;
   logic                 nz_seen;
   logic [DIGITS-1:0]    lz;
   logic [DIGITS:0]      lz_ext;
   logic [7*DIGITS-1:0]  seg_c;

   function automatic logic [6:0] seg_lut(input logic [3:0] d);
      case (d)
         4'd0:    seg_lut = 7'h40;
         4'd1:    seg_lut = 7'h79;
         4'd2:    seg_lut = 7'h24;
         4'd3:    seg_lut = 7'h30;
         4'd4:    seg_lut = 7'h19;
         4'd5:    seg_lut = 7'h12;
         4'd6:    seg_lut = 7'h02;
         4'd7:    seg_lut = 7'h78;
         4'd8:    seg_lut = 7'h00;
         4'd9:    seg_lut = 7'h10;
         default: seg_lut = 7'h7F;
      endcase
   endfunction

   assign neg_in = (SIGNED != 0) && bin_i[BIN_W-1];
   assign busy_o = (state_q != IDLE);

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = SHIFT;
         SHIFT:   if (cnt_q == CNT_W'(1)) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Add 3 to every scratch digit >= 5 ahead of the shift
   always_comb begin
      scr_adj = scr_q;
      for (int i = 0; i < SCR_D; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
   end

   // Capture on start, then shift one magnitude bit into the scratch per cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mag_q  <= '0;
         scr_q  <= '0;
         cnt_q  <= '0;
         sign_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  // Negating the most-negative value yields 2^(BIN_W-1), which is
                  // the correct magnitude when read as unsigned.
                  mag_q  <= neg_in ? -bin_i : bin_i;
                  sign_q <= neg_in;
                  scr_q  <= '0;
                  cnt_q  <= CNT_W'(BIN_W);
               end
            end
            SHIFT: begin
               scr_q <= {scr_adj[4*SCR_D-2:0], mag_q[BIN_W-1]};
               mag_q <= {mag_q[BIN_W-2:0], 1'b0};
               cnt_q <= cnt_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Overflow, leading-zero mask and segment patterns from the final scratch
   always_comb begin
      // A negative value needs the top field free for the minus sign.
      ovf_c = sign_q && (scr_q[4*(DIGITS-1) +: 4] != 4'd0);
      for (int i = DIGITS; i < SCR_D; i++) begin
         if (scr_q[4*i +: 4] != 4'd0) ovf_c = 1'b1;
      end

      nz_seen = 1'b0;
      lz      = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         lz[k]   = !nz_seen && (scr_q[4*k +: 4] == 4'd0) && (k != 0);
         nz_seen = nz_seen | (scr_q[4*k +: 4] != 4'd0);
      end
      // lz_ext[k] is the blank flag of the field to the right of field k.
      lz_ext = {lz, 1'b0};

      seg_c = '0;
      for (int k = 0; k < DIGITS; k++) begin
         seg_c[7*k +: 7] = seg_lut(scr_q[4*k +: 4]);
         if (BLANK_LZ != 0) begin
            if (lz[k]) seg_c[7*k +: 7] = 7'h7F;
            if (sign_q && lz[k] && !lz_ext[k]) seg_c[7*k +: 7] = 7'h3F;
         end else if (sign_q && (k == DIGITS - 1)) begin
            seg_c[7*k +: 7] = 7'h3F;
         end
         if (ovf_c) seg_c[7*k +: 7] = 7'h3F;
      end
   end

   // Result registers: updated only when leaving FINISH, held otherwise
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         done_o <= 1'b0;
         bcd_o  <= '0;
         neg_o  <= 1'b0;
         ovf_o  <= 1'b0;
         seg_o  <= {DIGITS{7'h7F}};
      end else begin
         done_o <= (state_q == FINISH);
         if (state_q == FINISH) begin
            bcd_o <= scr_q[4*DIGITS-1:0];
            neg_o <= sign_q;
            ovf_o <= ovf_c;
            seg_o <= seg_c;
         end
      end
   end

endmodule

// File: tb/tb_bin_bcd_display.sv
// Bench for bin_bcd_display: four configurations, directed vectors, a
// scoreboard queue per instance drained by a done-triggered monitor.

module tb_bin_bcd_display;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Cycle stamp for latency checks
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [39:0] bcd;
      logic [69:0] seg;
      logic        neg;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t q0[$], q1[$], q2[$], q3[$];

   // u0: defaults  u1: signed 8b/4d  u2: 16b/4d  u3: no blanking
   logic        st0, st1, st2, st3;
   logic [15:0] bin0, bin2, bin3;
   logic [7:0]  bin1;
   logic        busy0, busy1, busy2, busy3;
   logic        done0, done1, done2, done3;
   logic [19:0] bcd0, bcd3;
   logic [15:0] bcd1, bcd2;
   logic        neg0, neg1, neg2, neg3;
   logic        ovf0, ovf1, ovf2, ovf3;
   logic [34:0] seg0, seg3;
   logic [27:0] seg1, seg2;

   bin_bcd_display u0 (
      .clk_i(clk), .rst_i(rst), .start_i(st0), .bin_i(bin0), .busy_o(busy0),
      .done_o(done0), .bcd_o(bcd0), .neg_o(neg0), .ovf_o(ovf0), .seg_o(seg0));

   bin_bcd_display #(.BIN_W(8), .DIGITS(4), .SIGNED(1)) u1 (
      .clk_i(clk), .rst_i(rst), .start_i(st1), .bin_i(bin1), .busy_o(busy1),
      .done_o(done1), .bcd_o(bcd1), .neg_o(neg1), .ovf_o(ovf1), .seg_o(seg1));

   bin_bcd_display #(.BIN_W(16), .DIGITS(4)) u2 (
      .clk_i(clk), .rst_i(rst), .start_i(st2), .bin_i(bin2), .busy_o(busy2),
      .done_o(done2), .bcd_o(bcd2), .neg_o(neg2), .ovf_o(ovf2), .seg_o(seg2));

   bin_bcd_display #(.BLANK_LZ(0)) u3 (
      .clk_i(clk), .rst_i(rst), .start_i(st3), .bin_i(bin3), .busy_o(busy3),
      .done_o(done3), .bcd_o(bcd3), .neg_o(neg3), .ovf_o(ovf3), .seg_o(seg3));

   task automatic cmp(input string nm, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic score(input string tag, input exp_t e, input logic [39:0] b,
                        input logic [69:0] s, input logic n, input logic o);
      cmp({tag, "_latency"}, 70'(cyc), 70'(e.cyc));
      cmp({tag, "_bcd"}, 70'(b), 70'(e.bcd));
      cmp({tag, "_seg"}, s, e.seg);
      cmp({tag, "_neg"}, 70'(n), 70'(e.neg));
      cmp({tag, "_ovf"}, 70'(o), 70'(e.ovf));
   endtask

   task automatic spurious(input string tag);
      checks++;
      errors++;
      $display("FAIL %s_unexpected_done actual=1 required=0 at cycle %0d", tag, cyc);
   endtask

   // Monitors: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) if (done0) begin
      if (q0.size() == 0) spurious("u0");
      else score("u0", q0.pop_front(), 40'(bcd0), 70'(seg0), neg0, ovf0);
   end
   always @(negedge clk) if (done1) begin
      if (q1.size() == 0) spurious("u1");
      else score("u1", q1.pop_front(), 40'(bcd1), 70'(seg1), neg1, ovf1);
   end
   always @(negedge clk) if (done2) begin
      if (q2.size() == 0) spurious("u2");
      else score("u2", q2.pop_front(), 40'(bcd2), 70'(seg2), neg2, ovf2);
   end
   always @(negedge clk) if (done3) begin
      if (q3.size() == 0) spurious("u3");
      else score("u3", q3.pop_front(), 40'(bcd3), 70'(seg3), neg3, ovf3);
   end

   // Raise start on instance u (called at a negedge) and queue the expectation
   task automatic issue(input int u, input logic [15:0] b, input logic [39:0] eb,
                        input logic [69:0] es, input logic en, input logic eo);
      exp_t e;
      e.bcd = eb;
      e.seg = es;
      e.neg = en;
      e.ovf = eo;
      e.cyc = cyc + ((u == 1) ? 8 : 16) + 2;
      case (u)
         0: begin st0 = 1'b1; bin0 = b;      q0.push_back(e); end
         1: begin st1 = 1'b1; bin1 = b[7:0]; q1.push_back(e); end
         2: begin st2 = 1'b1; bin2 = b;      q2.push_back(e); end
         default: begin st3 = 1'b1; bin3 = b; q3.push_back(e); end
      endcase
   endtask

   task automatic drop_starts();
      st0 = 1'b0; st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
   endtask

   // Pulse start for one cycle, then wait (bounded) for the instance to go quiet
   task automatic convert(input int u, input logic [15:0] b, input logic [39:0] eb,
                          input logic [69:0] es, input logic en, input logic eo);
      logic seen;
      issue(u, b, eb, es, en, eo);
      @(negedge clk);
      drop_starts();
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = (u == 0) ? done0 : (u == 1) ? done1 : (u == 2) ? done2 : done3;
      end
      cmp("done_within_bound", 70'(seen), 70'(1));
      @(negedge clk);
   endtask

   initial begin
      int   n;
      logic seen;
      drop_starts();
      bin0 = '0; bin1 = '0; bin2 = '0; bin3 = '0;

      repeat (3) @(negedge clk);
      cmp("rst_busy", 70'(busy0), 70'(0));
      cmp("rst_done", 70'(done0), 70'(0));
      cmp("rst_bcd", 70'(bcd0), 70'(0));
      cmp("rst_seg", 70'(seg0), 70'({5{7'h7F}}));
      cmp("rst_neg_ovf", 70'({neg0, ovf0}), 70'(0));
      cmp("rst_seg_u1", 70'(seg1), 70'({4{7'h7F}}));
      rst = 1'b0;
      @(negedge clk);

      // Full-scale value, latency and busy length
      issue(0, 16'd65535, 40'h65535, 70'({7'h02, 7'h12, 7'h12, 7'h30, 7'h12}), 1'b0, 1'b0);
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         drop_starts();
         if (done0) seen = 1'b1;
         else if (busy0) n++;
      end
      cmp("busy_cycles", 70'(n), 70'(17));
      cmp("busy_low_at_done", 70'(busy0), 70'(0));
      @(negedge clk);

      // Zero, an ignored start mid-conversion, then a held start for 907
      issue(0, 16'd0, 40'h0, 70'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}), 1'b0, 1'b0);
      @(negedge clk);
      drop_starts();
      repeat (3) @(negedge clk);
      st0 = 1'b1; bin0 = 16'd555;
      @(negedge clk);
      st0 = 1'b0;
      repeat (3) @(negedge clk);
      st0 = 1'b1; bin0 = 16'd907;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done0) seen = 1'b1;
      end
      cmp("zero_done_within_bound", 70'(seen), 70'(1));
      issue(0, 16'd907, 40'h00907, 70'({7'h7F, 7'h7F, 7'h10, 7'h40, 7'h78}), 1'b0, 1'b0);
      @(negedge clk);
      drop_starts();
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done0) seen = 1'b1;
      end
      cmp("b2b_done_within_bound", 70'(seen), 70'(1));
      @(negedge clk);

      // Signed: most-negative value and a small negative value
      convert(1, 16'h0080, 40'h0128, 70'({7'h3F, 7'h79, 7'h24, 7'h00}), 1'b1, 1'b0);
      convert(1, 16'h00F9, 40'h0007, 70'({7'h7F, 7'h7F, 7'h3F, 7'h78}), 1'b1, 1'b0);

      // Too few digits: overflow, then the largest value that fits
      convert(2, 16'd12345, 40'h2345, 70'({4{7'h3F}}), 1'b0, 1'b1);
      convert(2, 16'd9999, 40'h9999, 70'({4{7'h10}}), 1'b0, 1'b0);

      // No leading-zero blanking
      convert(3, 16'd42, 40'h00042, 70'({7'h40, 7'h40, 7'h40, 7'h19, 7'h24}), 1'b0, 1'b0);

      // Reset eight cycles into a conversion aborts it and clears outputs
      st0 = 1'b1; bin0 = 16'd50000;
      @(negedge clk);
      drop_starts();
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      cmp("abort_busy", 70'(busy0), 70'(0));
      cmp("abort_done", 70'(done0), 70'(0));
      cmp("abort_bcd", 70'(bcd0), 70'(0));
      cmp("abort_seg", 70'(seg0), 70'({5{7'h7F}}));
      rst = 1'b0;
      repeat (25) @(negedge clk);
      convert(0, 16'd1234, 40'h01234, 70'({7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}), 1'b0, 1'b0);

      repeat (5) @(negedge clk);
      cmp("u0_pending", 70'(q0.size()), 70'(0));
      cmp("u1_pending", 70'(q1.size()), 70'(0));
      cmp("u2_pending", 70'(q2.size()), 70'(0));
      cmp("u3_pending", 70'(q3.size()), 70'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
